// File: rtl/rv32i_mem_stage_if.sv
// -----------------------------------------------------------------------------
// rv32i_mem_stage_if
// Data-memory request/acknowledge bus between the memory pipeline stage
// (master) and the data memory (slave).
//
// Signals:
//   req    master->slave  request, held until ack or abandon
//   we     master->slave  1 = write
//   addr   master->slave  word-aligned byte address
//   wdata  master->slave  lane-replicated store data
//   be     master->slave  byte enables
//   rdata  slave->master  read data, valid with ack
//   ack    slave->master  transfer complete (may coincide with first req cycle)
// -----------------------------------------------------------------------------
interface rv32i_mem_stage_if;
   logic        req;
   logic        we;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [3:0]  be;
   logic [31:0] rdata;
   logic        ack;

   modport master (output req, we, addr, wdata, be, input rdata, ack);
   modport slave  (input req, we, addr, wdata, be, output rdata, ack);
endinterface

// File: rtl/rv32i_mem_stage.sv
// -----------------------------------------------------------------------------
// rv32i_mem_stage
// RV32I memory-access pipeline stage between execute and writeback. Performs
// loads/stores over a variable-latency req/ack bus with byte lanes and
// sign/zero extension, stalls upstream while a transfer is outstanding,
// forwards its result to decode and registers results for writeback.
//
// Parameters:
//   TIMEOUT_CYCLES  cycles spent waiting in BUSY before an access is abandoned
//
// Optional feature (compile-time macro MISALIGN_CHECK_EN):
//   defined   : misaligned LH/LHU/SH/LW/SW are suppressed and flagged
//   undefined : low address bits only select lanes, misalign_err stays 0
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   alu_in              effective address or ALU result from execute
//   iw_in, pc_in        instruction word / PC from execute
//   wb_reg_in, wb_en_in destination register / writeback enable
//   w_en_in             store enable (qualifies the store opcode)
//   rs2_data_in         store data
//   dmem                data-memory bus (master modport)
//   mem_stall           hold execute/decode/fetch this cycle
//   wb_data_out, iw_out, pc_out, wb_reg_out, wb_en_out  registered to writeback
//   df_mem_enable, df_mem_reg, df_mem_data             forwarding to decode
//   bus_err             one-cycle pulse after an abandoned access
//   misalign_err        one-cycle pulse after a suppressed misaligned access
// -----------------------------------------------------------------------------
module rv32i_mem_stage #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [31:0]       alu_in,
   input  logic [31:0]       iw_in,
   input  logic [31:0]       pc_in,
   input  logic [4:0]        wb_reg_in,
   input  logic              wb_en_in,
   input  logic              w_en_in,
   input  logic [31:0]       rs2_data_in,
   rv32i_mem_stage_if.master dmem,
   output logic              mem_stall,
   output logic [31:0]       wb_data_out,
   output logic [31:0]       iw_out,
   output logic [31:0]       pc_out,
   output logic [4:0]        wb_reg_out,
   output logic              wb_en_out,
   output logic              df_mem_enable,
   output logic [4:0]        df_mem_reg,
   output logic [31:0]       df_mem_data,
   output logic              bus_err,
   output logic              misalign_err
);

   localparam logic [6:0]  OPC_LOAD  = 7'b0000011;
   localparam logic [6:0]  OPC_STORE = 7'b0100011;
   localparam logic [31:0] NOP_IW    = 32'h0000_0013;
   localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT_CYCLES);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   state_t      state_r;
   state_t      state_nx_s;
   logic [15:0] cnt_r;
   logic [15:0] cnt_nx_s;

   logic [6:0]  opcode_s;
   logic [2:0]  funct3_s;
   logic        is_load_s;
   logic        is_store_s;
   logic        f3_ok_s;
   logic        misalign_s;
   logic        mem_op_s;
   logic        req_s;
   logic        ack_s;
   logic        abandon_s;
   logic        stall_s;
   logic [31:0] result_s;
   logic        wb_en_eff_s;

   // Legal load widths: LB, LH, LW, LBU, LHU.
   function automatic logic load_f3_ok(input logic [2:0] f3);
      case (f3)
         3'b000, 3'b001, 3'b010, 3'b100, 3'b101: load_f3_ok = 1'b1;
         default:                                load_f3_ok = 1'b0;
      endcase
   endfunction

   // Legal store widths: SB, SH, SW.
   function automatic logic store_f3_ok(input logic [2:0] f3);
      case (f3)
         3'b000, 3'b001, 3'b010: store_f3_ok = 1'b1;
         default:                store_f3_ok = 1'b0;
      endcase
   endfunction

   // Byte enables from access width (funct3[1:0]) and the low address bits.
   function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] a);
      case (f3[1:0])
         2'b00:   lane_be = 4'b0001 << a;
         2'b01:   lane_be = a[1] ? 4'b1100 : 4'b0011;
         2'b10:   lane_be = 4'b1111;
         default: lane_be = 4'b0000;
      endcase
   endfunction

   // Store data replicated across every lane so the memory only needs be.
   function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] d);
      case (f3[1:0])
         2'b00:   store_wdata = {4{d[7:0]}};
         2'b01:   store_wdata = {2{d[15:0]}};
         2'b10:   store_wdata = d;
         default: store_wdata = 32'h0000_0000;
      endcase
   endfunction

   // Lane extraction plus sign/zero extension of the returned word.
   function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] a,
                                                input logic [31:0] d);
      logic [31:0] shifted;
      logic [15:0] half;
      shifted = d >> {a, 3'b000};
      half    = a[1] ? d[31:16] : d[15:0];
      case (f3)
         3'b000:  load_extract = {{24{shifted[7]}}, shifted[7:0]};
         3'b100:  load_extract = {24'h00_0000, shifted[7:0]};
         3'b001:  load_extract = {{16{half[15]}}, half};
         3'b101:  load_extract = {16'h0000, half};
         3'b010:  load_extract = d;
         default: load_extract = 32'h0000_0000;
      endcase
   endfunction

   // Instruction decode and qualification of the memory operation.
   always_comb begin
      opcode_s   = iw_in[6:0];
      funct3_s   = iw_in[14:12];
      is_load_s  = (opcode_s == OPC_LOAD);
      is_store_s = (opcode_s == OPC_STORE) & w_en_in;
      if (is_load_s) begin
         f3_ok_s = load_f3_ok(funct3_s);
      end else if (is_store_s) begin
         f3_ok_s = store_f3_ok(funct3_s);
      end else begin
         f3_ok_s = 1'b0;
      end
`ifdef MISALIGN_CHECK_EN
      case (funct3_s[1:0])
         2'b01:   misalign_s = f3_ok_s & alu_in[0];
         2'b10:   misalign_s = f3_ok_s & (alu_in[1:0] != 2'b00);
         default: misalign_s = 1'b0;
      endcase
`else
      misalign_s = 1'b0;
`endif
      mem_op_s = f3_ok_s & ~misalign_s;
   end

   // FSM state register with saturating wait counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= ST_IDLE;
         cnt_r   <= 16'd0;
      end else begin
         state_r <= state_nx_s;
         cnt_r   <= cnt_nx_s;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_nx_s = state_r;
      cnt_nx_s   = cnt_r;
      case (state_r)
         ST_IDLE: begin
            if (mem_op_s & ~ack_s) begin
               state_nx_s = ST_BUSY;
               cnt_nx_s   = 16'd1;
            end else begin
               state_nx_s = ST_IDLE;
               cnt_nx_s   = 16'd0;
            end
         end
         ST_BUSY: begin
            if (ack_s | abandon_s) begin
               state_nx_s = ST_IDLE;
               cnt_nx_s   = 16'd0;
            end else if (cnt_r != 16'hFFFF) begin
               state_nx_s = ST_BUSY;
               cnt_nx_s   = cnt_r + 16'd1;
            end else begin
               state_nx_s = ST_BUSY;
               cnt_nx_s   = cnt_r;
            end
         end
         default: begin
            state_nx_s = ST_IDLE;
            cnt_nx_s   = 16'd0;
         end
      endcase
   end

   // FSM outputs: the request tracks the (stalled, hence stable) upstream
   // operation in both states; an ack in the timeout cycle beats the abandon.
   always_comb begin
      req_s     = mem_op_s & ~reset;
      ack_s     = dmem.ack & req_s;
      abandon_s = (state_r == ST_BUSY) & (cnt_r == TIMEOUT_C) & ~ack_s;
      stall_s   = mem_op_s & ~ack_s & ~abandon_s;
   end

   // Bus drive; addr/we/be/wdata derive only from stalled-stable inputs.
   always_comb begin
      dmem.req   = req_s;
      dmem.we    = req_s & is_store_s;
      dmem.addr  = {alu_in[31:2], 2'b00};
      dmem.wdata = store_wdata(funct3_s, rs2_data_in);
      if (req_s) begin
         dmem.be = lane_be(funct3_s, alu_in[1:0]);
      end else begin
         dmem.be = 4'b0000;
      end
   end

   // Stage result and effective writeback enable.
   always_comb begin
      result_s    = alu_in;
      wb_en_eff_s = wb_en_in;
      if (is_load_s) begin
         if (mem_op_s & ack_s) begin
            result_s    = load_extract(funct3_s, alu_in[1:0], dmem.rdata);
            wb_en_eff_s = wb_en_in;
         end else begin
            // illegal width, misaligned, waiting or abandoned
            result_s    = 32'h0000_0000;
            wb_en_eff_s = 1'b0;
         end
      end else if (is_store_s) begin
         if (mem_op_s & ack_s) begin
            result_s    = alu_in;
            wb_en_eff_s = wb_en_in;
         end else if (mem_op_s) begin
            // waiting or abandoned
            result_s    = 32'h0000_0000;
            wb_en_eff_s = 1'b0;
         end else begin
            // suppressed store: nothing written to memory or the register file
            result_s    = alu_in;
            wb_en_eff_s = 1'b0;
         end
      end else begin
         result_s    = alu_in;
         wb_en_eff_s = wb_en_in;
      end
   end

   // Forwarding and stall outputs.
   always_comb begin
      mem_stall     = stall_s;
      df_mem_enable = wb_en_in & ~stall_s;
      df_mem_reg    = wb_reg_in;
      df_mem_data   = result_s;
   end

   // Writeback pipeline register; stall cycles insert a bubble.
   always_ff @(posedge clk) begin
      if (reset) begin
         wb_data_out  <= 32'h0000_0000;
         iw_out       <= NOP_IW;
         pc_out       <= 32'h0000_0000;
         wb_reg_out   <= 5'd0;
         wb_en_out    <= 1'b0;
         bus_err      <= 1'b0;
         misalign_err <= 1'b0;
      end else begin
         bus_err      <= abandon_s;
         misalign_err <= misalign_s;
         if (stall_s) begin
            wb_data_out <= 32'h0000_0000;
            iw_out      <= NOP_IW;
            pc_out      <= 32'h0000_0000;
            wb_reg_out  <= 5'd0;
            wb_en_out   <= 1'b0;
         end else begin
            wb_data_out <= result_s;
            iw_out      <= iw_in;
            pc_out      <= pc_in;
            wb_reg_out  <= wb_reg_in;
            wb_en_out   <= wb_en_eff_s;
         end
      end
   end

endmodule

// File: tb/tb_rv32i_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_rv32i_mem_stage
// Directed scoreboard bench for rv32i_mem_stage (TIMEOUT_CYCLES = 4).
// Expected results are pushed when an operation is driven and popped when the
// stage produces its non-bubble output. Honours MISALIGN_CHECK_EN.
// -----------------------------------------------------------------------------
module tb_rv32i_mem_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] alu_in, iw_in, pc_in, rs2_data_in;
   logic [4:0]  wb_reg_in;
   logic        wb_en_in, w_en_in;
   logic        mem_stall;
   logic [31:0] wb_data_out, iw_out, pc_out;
   logic [4:0]  wb_reg_out;
   logic        wb_en_out;
   logic        df_mem_enable;
   logic [4:0]  df_mem_reg;
   logic [31:0] df_mem_data;
   logic        bus_err, misalign_err;

   rv32i_mem_stage_if dmem_if ();

   rv32i_mem_stage #(.TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .reset(reset), .alu_in(alu_in), .iw_in(iw_in), .pc_in(pc_in),
      .wb_reg_in(wb_reg_in), .wb_en_in(wb_en_in), .w_en_in(w_en_in),
      .rs2_data_in(rs2_data_in), .dmem(dmem_if), .mem_stall(mem_stall),
      .wb_data_out(wb_data_out), .iw_out(iw_out), .pc_out(pc_out),
      .wb_reg_out(wb_reg_out), .wb_en_out(wb_en_out),
      .df_mem_enable(df_mem_enable), .df_mem_reg(df_mem_reg),
      .df_mem_data(df_mem_data), .bus_err(bus_err), .misalign_err(misalign_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] iw, pc, data, addr, wdata;
      logic [3:0]  be;
      logic        en, we, berr, mis;
      int          req_n, stall_n;
   } exp_t;

   exp_t        sb_q[$];
   int          total = 0;
   int          bad   = 0;
   logic [31:0] pc_drv = 32'h0000_1000;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      iw_in = NOP; alu_in = 32'h0; rs2_data_in = 32'h0; pc_in = 32'h0;
      wb_reg_in = 5'd0; wb_en_in = 1'b0; w_en_in = 1'b0;
   endtask

   // Drive one operation starting at a negedge, respond on the bus with ack in
   // cycle ack_at (-1 = never), and compare against the scoreboard entry.
   task automatic op(input logic [31:0] iw, alu, rs2, input logic w_en, wb_en,
                     input int ack_at, input logic [31:0] rdata,
                     input logic [31:0] x_data, input logic x_en, input int x_req, x_stall,
                     input logic x_berr, x_mis, x_we, input logic [3:0] x_be,
                     input logic [31:0] x_wdata, x_addr);
      exp_t e, g;
      int req_n, stall_n, bub_n, chg_n, cyc;
      logic done, stall_now, df_en_l;
      logic [31:0] df_data_l, a_c, w_c;
      logic [4:0]  df_reg_l;
      logic [3:0]  be_c;
      logic        we_c;
      pc_drv += 32'd4;
      e = '{iw: iw, pc: pc_drv, data: x_data, addr: x_addr, wdata: x_wdata, be: x_be,
            en: x_en, we: x_we, berr: x_berr, mis: x_mis, req_n: x_req, stall_n: x_stall};
      sb_q.push_back(e);
      iw_in = iw; alu_in = alu; rs2_data_in = rs2; w_en_in = w_en; wb_en_in = wb_en;
      wb_reg_in = iw[11:7]; pc_in = pc_drv;
      req_n = 0; stall_n = 0; bub_n = 0; chg_n = 0; cyc = 0; done = 1'b0;
      df_en_l = 1'b0; df_data_l = 32'h0; df_reg_l = 5'd0;
      a_c = 32'h0; w_c = 32'h0; be_c = 4'h0; we_c = 1'b0;
      while (!done && cyc < 40) begin
         dmem_if.ack   = (cyc == ack_at);
         dmem_if.rdata = rdata;
         #1;
         if (dmem_if.req) begin
            if (req_n == 0) begin
               a_c = dmem_if.addr; w_c = dmem_if.wdata; be_c = dmem_if.be; we_c = dmem_if.we;
            end else if ({a_c, w_c, be_c, we_c} !== {dmem_if.addr, dmem_if.wdata, dmem_if.be, dmem_if.we}) begin
               chg_n++;
            end
            req_n++;
         end
         stall_now = mem_stall;
         if (stall_now) stall_n++;
         df_en_l = df_mem_enable; df_data_l = df_mem_data; df_reg_l = df_mem_reg;
         @(posedge clk);
         #1;
         if (stall_now) begin
            chk("bubble_en", {31'h0, wb_en_out}, 32'h0);
            chk("bubble_iw", iw_out, NOP);
            bub_n++;
         end else begin
            done = 1'b1;
         end
         @(negedge clk);
         dmem_if.ack = 1'b0;
         cyc++;
      end
      g = sb_q.pop_front();
      if (!done) begin
         chk("wait_bound", 32'h0, 32'h1);
      end else begin
         chk("wb_data", wb_data_out, g.data);
         chk("wb_en", {31'h0, wb_en_out}, {31'h0, g.en});
         chk("iw_out", iw_out, g.iw);
         chk("pc_out", pc_out, g.pc);
         chk("wb_reg", {27'h0, wb_reg_out}, {27'h0, g.iw[11:7]});
         chk("bus_err", {31'h0, bus_err}, {31'h0, g.berr});
         chk("misalign_err", {31'h0, misalign_err}, {31'h0, g.mis});
         chk("req_cycles", req_n, g.req_n);
         chk("stall_cycles", stall_n, g.stall_n);
         chk("bubbles", bub_n, g.stall_n);
         chk("df_data", df_data_l, g.data);
         chk("df_en", {31'h0, df_en_l}, {31'h0, wb_en});
         chk("df_reg", {27'h0, df_reg_l}, {27'h0, g.iw[11:7]});
         if (g.req_n > 0) begin
            chk("addr", a_c, g.addr);
            chk("we", {31'h0, we_c}, {31'h0, g.we});
            chk("bus_stable", chg_n, 0);
            if (g.we) begin
               chk("be", {28'h0, be_c}, {28'h0, g.be});
               chk("wdata", w_c, g.wdata);
            end
         end
      end
      idle_inputs();
   endtask

   initial begin
      reset = 1'b1;
      idle_inputs();
      dmem_if.ack = 1'b0;
      dmem_if.rdata = 32'h0;
      @(posedge clk); @(posedge clk); #1;
      chk("rst_wb_data", wb_data_out, 32'h0);
      chk("rst_iw", iw_out, NOP);
      chk("rst_pc", pc_out, 32'h0);
      chk("rst_wb_en", {31'h0, wb_en_out}, 32'h0);
      chk("rst_bus_err", {31'h0, bus_err}, 32'h0);
      chk("rst_misalign", {31'h0, misalign_err}, 32'h0);
      chk("rst_req", {31'h0, dmem_if.req}, 32'h0);
      @(negedge clk);
      reset = 1'b0;

      //  iw            alu          rs2          w  we ack rdata        | data         en req st be ms we be     wdata        addr
      op(32'h00100093, 32'h1234,    32'h0,       0, 1, -1, 32'h0,        32'h1234,     1, 0, 0, 0, 0, 0, 4'h0, 32'h0,       32'h0);     // ADDI
      op(32'h00008103, 32'h103,     32'h0,       0, 1, 0,  32'h80FFFF11, 32'hFFFFFF80, 1, 1, 0, 0, 0, 0, 4'h0, 32'h0,       32'h100);   // LB
      op(32'h00209123, 32'h102,     32'hABCD5678,1, 0, 3,  32'h0,        32'h102,      0, 4, 3, 0, 0, 1, 4'hC, 32'h56785678,32'h100);   // SH
      op(32'h0000A183, 32'h400,     32'h0,       0, 1, -1, 32'h0,        32'h0,        0, 5, 4, 1, 0, 0, 4'h0, 32'h0,       32'h400);   // LW timeout
      op(32'h0000C103, 32'h101,     32'h0,       0, 1, 1,  32'h123480FF, 32'h00000080, 1, 2, 1, 0, 0, 0, 4'h0, 32'h0,       32'h100);   // LBU
      op(32'h00009103, 32'h102,     32'h0,       0, 1, 0,  32'h80017FFF, 32'hFFFF8001, 1, 1, 0, 0, 0, 0, 4'h0, 32'h0,       32'h100);   // LH
      op(32'h0000D103, 32'h100,     32'h0,       0, 1, 2,  32'h1234F00D, 32'h0000F00D, 1, 3, 2, 0, 0, 0, 4'h0, 32'h0,       32'h100);   // LHU
      op(32'h00208023, 32'h203,     32'h112233A5,1, 1, 0,  32'h0,        32'h203,      1, 1, 0, 0, 0, 1, 4'h8, 32'hA5A5A5A5,32'h200);   // SB
      op(32'h0020A023, 32'h300,     32'hDEADBEEF,1, 0, 1,  32'h0,        32'h300,      0, 2, 1, 0, 0, 1, 4'hF, 32'hDEADBEEF,32'h300);   // SW
      op(32'h0000B103, 32'h500,     32'h0,       0, 1, 0,  32'h55555555, 32'h0,        0, 0, 0, 0, 0, 0, 4'h0, 32'h0,       32'h0);     // illegal load
      op(32'h0020A023, 32'h600,     32'h12345678,0, 1, -1, 32'h0,        32'h600,      1, 0, 0, 0, 0, 0, 4'h0, 32'h0,       32'h0);     // store, w_en=0
`ifdef MISALIGN_CHECK_EN
      op(32'h0020A023, 32'h201,     32'hCAFEF00D,1, 0, 0,  32'h0,        32'h201,      0, 0, 0, 0, 1, 0, 4'h0, 32'h0,       32'h0);     // SW misaligned
`else
      op(32'h0020A023, 32'h201,     32'hCAFEF00D,1, 0, 0,  32'h0,        32'h201,      0, 1, 0, 0, 0, 1, 4'hF, 32'hCAFEF00D,32'h200);   // SW low bits ignored
`endif
      op(32'h0000A183, 32'h404,     32'h0,       0, 1, 4,  32'h0BADF00D, 32'h0BADF00D, 1, 5, 4, 0, 0, 0, 4'h0, 32'h0,       32'h404);   // ack wins at timeout

      // Reset while an LHU is outstanding in BUSY.
      iw_in = 32'h0000D103; alu_in = 32'h104; wb_en_in = 1'b1; wb_reg_in = 5'd2; pc_in = 32'h2000;
      dmem_if.ack = 1'b0;
      #1 chk("mid_req_before", {31'h0, dmem_if.req}, 32'h1);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1 chk("mid_req_drop", {31'h0, dmem_if.req}, 32'h0);
      @(posedge clk); #1;
      chk("mid_rst_iw", iw_out, NOP);
      chk("mid_rst_en", {31'h0, wb_en_out}, 32'h0);
      chk("mid_rst_data", wb_data_out, 32'h0);
      chk("mid_rst_pc", pc_out, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      idle_inputs();
      // Late ack arrives alongside a plain ALU op and must be ignored.
      op(32'h00100093, 32'h77,      32'h0,       0, 1, 0,  32'hFFFFFFFF, 32'h77,       1, 0, 0, 0, 0, 0, 4'h0, 32'h0,       32'h0);
      op(32'h0000C103, 32'h102,     32'h0,       0, 1, 0,  32'hAB00CD00, 32'h00000000, 1, 1, 0, 0, 0, 0, 4'h0, 32'h0,       32'h100);   // LBU after reset

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
